// File: rtl/bus_slave_regs.sv
// bus_slave_regs: bus slave with eight 32-bit registers and an asynchronous
// strobe/ready handshake.
//   reg 0..5 : read/write (reg 0 also drives ctrl_out)
//   reg 6    : read/write, or WAIT_CFG[3:0] when BUS_SLAVE_WAIT_EN is defined
//   reg 7    : ACC_CNT, read-only count of completed accesses
// Optional feature macro: BUS_SLAVE_WAIT_EN (programmable 0..15 wait states).
// rdy_n and rd_data are registered; rd_data is zero whenever rdy_n is high, so
// several slaves can be OR-combined on the bus.

module bus_slave_regs #(
    parameter logic [31:0] CTRL_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_n,
    output logic [31:0] ctrl_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_next_s;
    logic        rw_r;
    logic        rw_next_s;
    logic [31:0] wdata_r;
    logic [31:0] wdata_next_s;
    logic [31:0] regs_r [0:6];
    logic [31:0] acc_cnt_r;
    logic [3:0]  wait_eff_s;
    logic [31:0] read_val_s;
    logic [31:0] write_val_s;
    logic        rdy_n_r;
    logic [31:0] rd_data_r;

    assign rd_data  = rd_data_r;
    assign rdy_n    = rdy_n_r;
    assign ctrl_out = regs_r[0];

    // Effective wait-state count, sampled when a request is accepted.
`ifdef BUS_SLAVE_WAIT_EN
    assign wait_eff_s = regs_r[6][3:0];
`else
    assign wait_eff_s = 4'd0;
`endif

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of ACK.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        rw_next_s    = rw_r;
        wdata_next_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (!cs_n && !as_n) begin
                    idx_next_s   = addr[2:0];
                    rw_next_s    = rw;
                    wdata_next_s = wr_data;
                    if (wait_eff_s == 4'd0) begin
                        state_next_s = ACK;
                        cnt_next_s   = 4'd0;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = wait_eff_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                // Counter value k means k wait cycles remain including this one.
                if (cnt_r <= 4'd1) begin
                    state_next_s = ACK;
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = WAIT;
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ACK: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Read mux for the index that will be acknowledged next.
    always_comb begin
        read_val_s = 32'd0;
        case (idx_next_s)
            3'd0:    read_val_s = regs_r[0];
            3'd1:    read_val_s = regs_r[1];
            3'd2:    read_val_s = regs_r[2];
            3'd3:    read_val_s = regs_r[3];
            3'd4:    read_val_s = regs_r[4];
            3'd5:    read_val_s = regs_r[5];
`ifdef BUS_SLAVE_WAIT_EN
            3'd6:    read_val_s = {28'd0, regs_r[6][3:0]};
`else
            3'd6:    read_val_s = regs_r[6];
`endif
            3'd7:    read_val_s = acc_cnt_r;
            default: read_val_s = 32'd0;
        endcase
    end

    // Write data as stored; WAIT_CFG keeps only its low nibble.
    always_comb begin
        write_val_s = wdata_r;
`ifdef BUS_SLAVE_WAIT_EN
        if (idx_r == 3'd6) begin
            write_val_s = {28'd0, wdata_r[3:0]};
        end else begin
            write_val_s = wdata_r;
        end
`endif
    end

    // FSM state, latched request and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= 3'd0;
            rw_r      <= 1'b1;
            wdata_r   <= 32'd0;
            rdy_n_r   <= 1'b1;
            rd_data_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            rw_r    <= rw_next_s;
            wdata_r <= wdata_next_s;
            rdy_n_r <= (state_next_s == ACK) ? 1'b0 : 1'b1;
            // Data is captured on ACK entry, before the access count advances.
            rd_data_r <= ((state_next_s == ACK) && rw_next_s) ? read_val_s : 32'd0;
        end
    end

    // Register file and access counter; commits happen on the edge ending ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_r[0] <= CTRL_INIT;
            for (int i = 1; i < 7; i++) begin
                regs_r[i] <= 32'd0;
            end
            acc_cnt_r <= 32'd0;
        end else if (state_r == ACK) begin
            acc_cnt_r <= acc_cnt_r + 32'd1;
            if (!rw_r && (idx_r != 3'd7)) begin
                regs_r[idx_r] <= write_val_s;
            end
        end
    end

endmodule

// File: tb/tb_bus_slave_regs.sv
// tb_bus_slave_regs: scoreboard bench for bus_slave_regs. Expected read data
// is queued from a register model when each access is driven and popped when
// the slave acknowledges. Honours BUS_SLAVE_WAIT_EN when defined.

module tb_bus_slave_regs;

    localparam logic [31:0] CTRL_INIT = 32'hC0DE_0001;

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        as_n;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_n;
    logic [31:0] ctrl_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [0:6];
    logic [31:0] m_acc;
    logic [31:0] exp_q [$];

    bus_slave_regs #(.CTRL_INIT(CTRL_INIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .as_n     (as_n),
        .rw       (rw),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rdy_n    (rdy_n),
        .ctrl_out (ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_regs[0] = CTRL_INIT;
        for (int i = 1; i < 7; i++) m_regs[i] = 32'd0;
        m_acc = 32'd0;
    endtask

    function automatic int model_wait();
`ifdef BUS_SLAVE_WAIT_EN
        return int'(m_regs[6][3:0]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        if (idx == 3'd7) return m_acc;
`ifdef BUS_SLAVE_WAIT_EN
        if (idx == 3'd6) return {28'd0, m_regs[6][3:0]};
`endif
        return m_regs[idx];
    endfunction

    task automatic model_write(input logic [2:0] idx, input logic [31:0] data);
        if (idx != 3'd7) begin
`ifdef BUS_SLAVE_WAIT_EN
            if (idx == 3'd6) m_regs[6] = {28'd0, data[3:0]};
            else m_regs[idx] = data;
`else
            m_regs[idx] = data;
`endif
        end
    endtask

    // One bus access: strobe for one edge, then scramble inputs to show they
    // are ignored until ACK; checks latency, single-cycle ready and read data.
    task automatic do_access(input logic rd, input logic [2:0] idx, input logic [31:0] data);
        int          w;
        int          cyc;
        bit          got;
        logic [26:0] hi;
        logic [31:0] exp_v;
        w  = model_wait();
        hi = 27'($urandom);
        @(negedge clk);
        cs_n    = 1'b0;
        as_n    = 1'b0;
        rw      = rd;
        addr    = {hi, idx};
        wr_data = rd ? $urandom : data;
        if (rd) exp_q.push_back(model_read(idx));
        @(posedge clk);
        @(negedge clk);
        cs_n    = 1'b1;
        as_n    = 1'b1;
        rw      = ~rd;
        addr    = 30'($urandom);
        wr_data = $urandom;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            if (rdy_n == 1'b0) begin
                got = 1'b1;
            end else begin
                check_eq("rd_data_idle", rd_data, 32'd0);
                cyc++;
                @(negedge clk);
            end
        end
        if (!got) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("ack_latency", 32'(cyc), 32'(w + 1));
            if (rd) begin
                exp_v = exp_q.pop_front();
                check_eq("rd_data", rd_data, exp_v);
            end else begin
                model_write(idx, data);
            end
            m_acc = m_acc + 32'd1;
            @(negedge clk);
            check_eq("rdy_single_cycle", 32'(rdy_n), 32'd1);
            check_eq("rd_data_after_ack", rd_data, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] pat [0:5];
        reset   = 1'b1;
        cs_n    = 1'b1;
        as_n    = 1'b1;
        rw      = 1'b1;
        addr    = 30'd0;
        wr_data = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_rdy_n", 32'(rdy_n), 32'd1);
        check_eq("reset_rd_data", rd_data, 32'd0);
        check_eq("reset_ctrl_out", ctrl_out, CTRL_INIT);
        reset = 1'b0;

        // Basic write then read of reg 2, then the access count.
        do_access(1'b0, 3'd2, 32'h1234_5678);
        do_access(1'b1, 3'd2, 32'd0);
        do_access(1'b1, 3'd7, 32'd0);

        // Fill regs 0..5 and read back.
        for (int i = 0; i < 6; i++) begin
            pat[i] = $urandom;
            do_access(1'b0, 3'(i), pat[i]);
        end
        check_eq("ctrl_out_follow", ctrl_out, m_regs[0]);
        for (int i = 0; i < 6; i++) do_access(1'b1, 3'(i), 32'd0);

        // Reg 6: full register, or WAIT_CFG with low nibble only.
        do_access(1'b0, 3'd6, 32'hFFFF_FFF0);
        do_access(1'b1, 3'd6, 32'd0);
        do_access(1'b0, 3'd6, 32'h0000_0003);
        do_access(1'b1, 3'd6, 32'd0);
        do_access(1'b1, 3'd0, 32'd0);
        do_access(1'b0, 3'd6, 32'hABCD_EF0F);
        do_access(1'b1, 3'd1, 32'd0);
        do_access(1'b0, 3'd6, 32'h0000_0002);
        do_access(1'b1, 3'd6, 32'd0);

        // Strobe without chip select is ignored.
        @(negedge clk);
        cs_n = 1'b1;
        as_n = 1'b0;
        rw   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("cs_n_high_rdy", 32'(rdy_n), 32'd1);
        end
        as_n = 1'b1;
        do_access(1'b1, 3'd3, 32'd0);

        // Write to reg 7 is acknowledged but only counts.
        do_access(1'b0, 3'd7, 32'h5555_AAAA);
        do_access(1'b1, 3'd7, 32'd0);

        // Access counter wraps.
        @(negedge clk);
        force dut.acc_cnt_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.acc_cnt_r;
        m_acc = 32'hFFFF_FFFF;
        do_access(1'b1, 3'd7, 32'd0);
        do_access(1'b1, 3'd7, 32'd0);

        // Reset in the middle of a write aborts it.
        @(negedge clk);
        cs_n    = 1'b0;
        as_n    = 1'b0;
        rw      = 1'b0;
        addr    = {27'd0, 3'd1};
        wr_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cs_n = 1'b1;
        as_n = 1'b1;
`ifdef BUS_SLAVE_WAIT_EN
        check_eq("in_wait_rdy_n", 32'(rdy_n), 32'd1);
`endif
        reset = 1'b1;
        #1;
        check_eq("abort_rdy_n", 32'(rdy_n), 32'd1);
        check_eq("abort_rd_data", rd_data, 32'd0);
        check_eq("abort_ctrl_out", ctrl_out, CTRL_INIT);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        do_access(1'b1, 3'd1, 32'd0);
        do_access(1'b1, 3'd7, 32'd0);
        do_access(1'b1, 3'd0, 32'd0);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
